// File: rtl/sfo_search_controller.sv
// Sweeps SFO hypotheses for one CFO candidate: replays the bin buffer into the correlator
// per hypothesis and keeps the strict running maximum of the returned correlation.
module sfo_search_controller #(
  parameter int FFT_LEN_LOG2   = 9,
  parameter int SFO_INT_WIDTH  = 8,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 26,
  parameter int NUM_HYP_LOG2   = 6,
  parameter int WAIT_TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SFO_INT_WIDTH-1:0]  sfo_start_int,
  input  logic [SFO_FRAC_WIDTH-1:0] sfo_start_frac,
  input  logic [SFO_FRAC_WIDTH-1:0] sfo_step_frac,
  input  logic [NUM_HYP_LOG2-1:0]   num_hyp,
  output logic                      bin_rd_en,
  output logic [FFT_LEN_LOG2-1:0]   bin_rd_addr,
  output logic [SFO_INT_WIDTH-1:0]  corr_sfo_int,
  output logic [SFO_FRAC_WIDTH-1:0] corr_sfo_frac,
  output logic                      corr_reset,
  output logic                      corr_update,
  input  logic [CORR_WIDTH-1:0]     corr_in,
  input  logic                      corr_in_valid,
  output logic                      busy,
  output logic                      done,
  output logic [SFO_INT_WIDTH-1:0]  best_sfo_int,
  output logic [SFO_FRAC_WIDTH-1:0] best_sfo_frac,
  output logic [CORR_WIDTH-1:0]     best_corr,
  output logic [NUM_HYP_LOG2-1:0]   best_index,
  output logic                      timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COMPARE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int HYP_W  = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
  localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

  logic [2:0]                state;
  logic [SFO_FRAC_WIDTH-1:0] step_q;
  logic [NUM_HYP_LOG2-1:0]   last_idx;
  logic [NUM_HYP_LOG2-1:0]   hyp_idx;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [CORR_WIDTH-1:0]     corr_cap;
  logic [HYP_W-1:0]          hyp_next;

  // Fractional step is zero-extended so its carry ripples into the integer part,
  // and the integer part wraps naturally at the register width.
  assign hyp_next = {corr_sfo_int, corr_sfo_frac} + {{SFO_INT_WIDTH{1'b0}}, step_q};

  assign bin_rd_en  = (state == S_STREAM);
  assign corr_reset = (state == S_IDLE) || (state == S_LOAD);
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      step_q        <= '0;
      last_idx      <= '0;
      hyp_idx       <= '0;
      wait_cnt      <= '0;
      corr_cap      <= '0;
      bin_rd_addr   <= '0;
      corr_sfo_int  <= '0;
      corr_sfo_frac <= '0;
      corr_update   <= 1'b0;
      best_sfo_int  <= '0;
      best_sfo_frac <= '0;
      best_corr     <= '0;
      best_index    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      // Read data arrives one cycle after the strobe, so the update strobe trails it.
      corr_update <= (state == S_STREAM);

      case (state)
        S_IDLE: begin
          if (start) begin
            best_sfo_int  <= '0;
            best_sfo_frac <= '0;
            best_corr     <= '0;
            best_index    <= '0;
            timeout_err   <= 1'b0;
            if (num_hyp == '0) begin
              state <= S_DONE;
            end else begin
              corr_sfo_int  <= sfo_start_int;
              corr_sfo_frac <= sfo_start_frac;
              step_q        <= sfo_step_frac;
              last_idx      <= num_hyp - NUM_HYP_LOG2'(1);
              hyp_idx       <= '0;
              state         <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          bin_rd_addr <= '0;
          state       <= S_STREAM;
        end

        S_STREAM: begin
          // Address wraps back to 0 after the last bin, leaving it clean for the next pass.
          bin_rd_addr <= bin_rd_addr + FFT_LEN_LOG2'(1);
          if (&bin_rd_addr) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (corr_in_valid) begin
            corr_cap <= corr_in;
            state    <= S_COMPARE;
          end else if (wait_cnt == WAIT_LAST) begin
            corr_cap    <= '0;
            timeout_err <= 1'b1;
            state       <= S_COMPARE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_COMPARE: begin
          // Strict compare: ties keep the earliest hypothesis.
          if (corr_cap > best_corr) begin
            best_corr     <= corr_cap;
            best_index    <= hyp_idx;
            best_sfo_int  <= corr_sfo_int;
            best_sfo_frac <= corr_sfo_frac;
          end
          if (hyp_idx == last_idx) begin
            state <= S_DONE;
          end else begin
            hyp_idx       <= hyp_idx + NUM_HYP_LOG2'(1);
            corr_sfo_int  <= hyp_next[HYP_W-1:SFO_FRAC_WIDTH];
            corr_sfo_frac <= hyp_next[SFO_FRAC_WIDTH-1:0];
            state         <= S_LOAD;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfo_search_controller.sv
// Directed bench for sfo_search_controller with N=8 and a behavioural correlator model.
module tb_sfo_search_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  sfo_start_int;
  logic [15:0] sfo_start_frac;
  logic [15:0] sfo_step_frac;
  logic [5:0]  num_hyp;
  logic        bin_rd_en;
  logic [2:0]  bin_rd_addr;
  logic [7:0]  corr_sfo_int;
  logic [15:0] corr_sfo_frac;
  logic        corr_reset;
  logic        corr_update;
  logic [25:0] corr_in;
  logic        corr_in_valid;
  logic        busy;
  logic        done;
  logic [7:0]  best_sfo_int;
  logic [15:0] best_sfo_frac;
  logic [25:0] best_corr;
  logic [5:0]  best_index;
  logic        timeout_err;

  sfo_search_controller #(
    .FFT_LEN_LOG2(3), .SFO_INT_WIDTH(8), .SFO_FRAC_WIDTH(16),
    .CORR_WIDTH(26), .NUM_HYP_LOG2(6), .WAIT_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sfo_start_int(sfo_start_int), .sfo_start_frac(sfo_start_frac),
    .sfo_step_frac(sfo_step_frac), .num_hyp(num_hyp),
    .bin_rd_en(bin_rd_en), .bin_rd_addr(bin_rd_addr),
    .corr_sfo_int(corr_sfo_int), .corr_sfo_frac(corr_sfo_frac),
    .corr_reset(corr_reset), .corr_update(corr_update),
    .corr_in(corr_in), .corr_in_valid(corr_in_valid),
    .busy(busy), .done(done),
    .best_sfo_int(best_sfo_int), .best_sfo_frac(best_sfo_frac),
    .best_corr(best_corr), .best_index(best_index), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Correlator model: scores a hypothesis two cycles after its 8th update strobe.
  int          tbl [8];
  bit          mute [8];
  int          hyp = -1;
  int          m_upd = 0;
  int          m_dly = 0;
  logic [7:0]  rec_int [8];
  logic [15:0] rec_frac [8];

  always @(posedge clk) begin
    if (!busy) hyp = -1;
    if (busy && corr_reset) begin
      hyp++;
      if (hyp < 8) begin
        rec_int[hyp]  = corr_sfo_int;
        rec_frac[hyp] = corr_sfo_frac;
      end
    end
    if (corr_reset) begin
      m_upd = 0;
      m_dly = 0;
      corr_in_valid <= 1'b0;
      corr_in       <= '0;
    end else if (corr_update) begin
      m_upd++;
    end else if (m_upd == 8 && hyp >= 0 && hyp < 8 && !mute[hyp]) begin
      m_dly++;
      if (m_dly == 2) begin
        corr_in_valid <= 1'b1;
        corr_in       <= 26'(tbl[hyp]);
      end
    end
  end

  // Stream monitor, sampled on the falling edge.
  logic prev_rd_en = 1'b0;
  int rd_idx = 0, rd_cnt = 0, upd_cnt = 0, lag_err = 0, addr_err = 0;
  int done_cnt = 0, rst_cyc = 0, busy_cyc = 0;

  always @(negedge clk) begin
    if (corr_update !== prev_rd_en) lag_err++;
    prev_rd_en = bin_rd_en;
    if (bin_rd_en) begin
      if (bin_rd_addr !== 3'(rd_idx)) addr_err++;
      rd_idx++;
      rd_cnt++;
    end else begin
      rd_idx = 0;
    end
    if (corr_update) upd_cnt++;
    if (done) done_cnt++;
    if (busy && corr_reset) rst_cyc++;
    if (busy) busy_cyc++;
  end

  int s_rd, s_upd, s_lag, s_addr, s_done, s_rst, s_busy;

  task automatic snap();
    s_rd = rd_cnt; s_upd = upd_cnt; s_lag = lag_err; s_addr = addr_err;
    s_done = done_cnt; s_rst = rst_cyc; s_busy = busy_cyc;
  endtask

  task automatic run_sweep(input logic [7:0] si, input logic [15:0] sf,
                           input logic [15:0] st, input logic [5:0] nh, output int lat);
    bit seen;
    @(negedge clk);
    snap();
    sfo_start_int  = si;
    sfo_start_frac = sf;
    sfo_step_frac  = st;
    num_hyp        = nh;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(nh != 0));
    seen = 0;
    lat  = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  int lat;
  bit found;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sfo_start_int = '0; sfo_start_frac = '0; sfo_step_frac = '0; num_hyp = '0;
    for (int i = 0; i < 8; i++) begin tbl[i] = 0; mute[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_corr_reset", 32'(corr_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(bin_rd_en), 32'd0);
    check("rst_update", 32'(corr_update), 32'd0);
    check("rst_best_corr", 32'(best_corr), 32'd0);
    reset = 1'b0;

    // Sweep 1: 3.0 .. 3.75, scores 10,50,50,20 -> first 50 wins.
    tbl[0] = 10; tbl[1] = 50; tbl[2] = 50; tbl[3] = 20;
    run_sweep(8'd3, 16'h0000, 16'h4000, 6'd4, lat);
    check("s1_best_index", 32'(best_index), 32'd1);
    check("s1_best_int", 32'(best_sfo_int), 32'd3);
    check("s1_best_frac", 32'(best_sfo_frac), 32'h4000);
    check("s1_best_corr", 32'(best_corr), 32'd50);
    check("s1_timeout", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("s1_hyp_int", 32'(rec_int[i]), 32'd3);
      check("s1_hyp_frac", 32'(rec_frac[i]), 32'(i * 16'h4000));
    end
    check("s1_rd_pulses", 32'(rd_cnt - s_rd), 32'd32);
    check("s1_upd_pulses", 32'(upd_cnt - s_upd), 32'd32);
    check("s1_update_lag", 32'(lag_err - s_lag), 32'd0);
    check("s1_addr_seq", 32'(addr_err - s_addr), 32'd0);
    check("s1_load_cycles", 32'(rst_cyc - s_rst), 32'd4);
    check("s1_busy_cycles", 32'(busy_cyc - s_busy), 32'd56);
    repeat (3) @(negedge clk);
    check("s1_done_pulses", 32'(done_cnt - s_done), 32'd1);
    check("s1_idle_hold", 32'(best_corr), 32'd50);

    // Sweep 2: second of three never returns valid -> 64-cycle WAIT, scored 0.
    tbl[0] = 30; tbl[1] = 99; tbl[2] = 20; mute[1] = 1;
    run_sweep(8'd1, 16'h0000, 16'h1000, 6'd3, lat);
    mute[1] = 0;
    check("s2_best_index", 32'(best_index), 32'd0);
    check("s2_best_corr", 32'(best_corr), 32'd30);
    check("s2_timeout", 32'(timeout_err), 32'd1);
    check("s2_busy_cycles", 32'(busy_cyc - s_busy), 32'd103);

    // Sweep 3: integer wrap 255.75 + 0.5 -> 0.25.
    tbl[0] = 5; tbl[1] = 7;
    run_sweep(8'd255, 16'hC000, 16'h8000, 6'd2, lat);
    check("s3_hyp0_int", 32'(rec_int[0]), 32'd255);
    check("s3_hyp0_frac", 32'(rec_frac[0]), 32'hC000);
    check("s3_hyp1_int", 32'(rec_int[1]), 32'd0);
    check("s3_hyp1_frac", 32'(rec_frac[1]), 32'h4000);
    check("s3_best_int", 32'(best_sfo_int), 32'd0);
    check("s3_best_frac", 32'(best_sfo_frac), 32'h4000);
    check("s3_best_corr", 32'(best_corr), 32'd7);
    check("s3_timeout", 32'(timeout_err), 32'd0);

    // Sweep 4: zero hypotheses -> immediate DONE, bests cleared.
    run_sweep(8'd9, 16'h1234, 16'h0100, 6'd0, lat);
    check("s4_done_latency", 32'(lat), 32'd0);
    check("s4_best_corr", 32'(best_corr), 32'd0);
    check("s4_best_index", 32'(best_index), 32'd0);
    check("s4_upd_pulses", 32'(upd_cnt - s_upd), 32'd0);

    // Reset in the middle of hypothesis 1's stream.
    tbl[0] = 10; tbl[1] = 50; tbl[2] = 50; tbl[3] = 20;
    @(negedge clk);
    sfo_start_int = 8'd3; sfo_start_frac = 16'h0; sfo_step_frac = 16'h4000; num_hyp = 6'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (bin_rd_en && hyp == 1 && bin_rd_addr == 3'd3) found = 1;
      else @(negedge clk);
    end
    check("s5_reached_stream", 32'(found), 32'd1);
    snap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("s5_corr_reset", 32'(corr_reset), 32'd1);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_rd_en", 32'(bin_rd_en), 32'd0);
    check("s5_best_corr", 32'(best_corr), 32'd0);
    repeat (20) @(negedge clk);
    check("s5_no_done", 32'(done_cnt - s_done), 32'd0);
    run_sweep(8'd3, 16'h0000, 16'h4000, 6'd4, lat);
    check("s6_best_index", 32'(best_index), 32'd1);
    check("s6_best_frac", 32'(best_sfo_frac), 32'h4000);
    check("s6_best_corr", 32'(best_corr), 32'd50);
    check("s6_update_lag", 32'(lag_err - s_lag), 32'd0);
    check("s6_busy_cycles", 32'(busy_cyc - s_busy), 32'd56);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
